// File: rtl/cellrv32_busswitch_n.sv
// N-port peripheral-bus switch: fixed-priority or round-robin arbitration and locally answered read-only ports.
// Optional BUSY watchdog is built when CELLRV32_BUSSWITCH_TIMEOUT_EN is defined.
module cellrv32_busswitch_n #(
   parameter int                   NUM_PORTS      = 3,
   parameter bit                   RR_EN          = 1'b1,
   parameter logic [NUM_PORTS-1:0] READ_ONLY_MASK = '0,
   parameter int                   TIMEOUT_CYCLES = 255,
   localparam int                  SW             = (NUM_PORTS > 2) ? $clog2(NUM_PORTS) : 1
) (
   input  logic                    clk_i,
   input  logic                    rstn_i,
   input  logic [NUM_PORTS-1:0]    c_bus_priv_i,
   input  logic [NUM_PORTS-1:0]    c_bus_cached_i,
   input  logic [32*NUM_PORTS-1:0] c_bus_addr_i,
   output logic [32*NUM_PORTS-1:0] c_bus_rdata_o,
   input  logic [32*NUM_PORTS-1:0] c_bus_wdata_i,
   input  logic [4*NUM_PORTS-1:0]  c_bus_ben_i,
   input  logic [NUM_PORTS-1:0]    c_bus_we_i,
   input  logic [NUM_PORTS-1:0]    c_bus_re_i,
   output logic [NUM_PORTS-1:0]    c_bus_ack_o,
   output logic [NUM_PORTS-1:0]    c_bus_err_o,
   output logic                    p_bus_priv_o,
   output logic                    p_bus_cached_o,
   output logic [SW-1:0]           p_bus_src_o,
   output logic [31:0]             p_bus_addr_o,
   output logic [31:0]             p_bus_wdata_o,
   output logic [3:0]              p_bus_ben_o,
   input  logic [31:0]             p_bus_rdata_i,
   output logic                    p_bus_we_o,
   output logic                    p_bus_re_o,
   input  logic                    p_bus_ack_i,
   input  logic                    p_bus_err_i
);

   typedef enum logic [1:0] {S_IDLE, S_RETIRE, S_BUSY} state_t;

   state_t               state;
   logic [SW-1:0]        grant, last_grant, win, sel, cand;
   logic [NUM_PORTS-1:0] rd_pend, wr_pend, wr_ok, req, ro_err, resp_clr;
   logic                 win_valid, win_strobe, rsp, tmo;
   int                   idx;

   // writes from read-only ports never become requests
   assign wr_ok = c_bus_we_i & ~READ_ONLY_MASK;
   assign req   = c_bus_re_i | wr_ok | rd_pend | wr_pend;

   always_comb begin
      win       = '0;
      win_valid = 1'b0;
      idx       = 0;
      cand      = '0;
      for (int k = 0; k < NUM_PORTS; k++) begin
         idx = RR_EN ? (int'(last_grant) + 1 + k) : k;
         if (idx >= NUM_PORTS) idx = idx - NUM_PORTS;
         cand = SW'(idx);
         if (!win_valid && req[cand]) begin
            win       = cand;
            win_valid = 1'b1;
         end
      end
   end

   assign sel        = (state == S_IDLE) ? win : grant;
   assign win_strobe = c_bus_re_i[win] | wr_ok[win];

   assign p_bus_src_o    = sel;
   assign p_bus_priv_o   = c_bus_priv_i[sel];
   assign p_bus_cached_o = c_bus_cached_i[sel];
   assign p_bus_addr_o   = c_bus_addr_i[32*int'(sel) +: 32];
   assign p_bus_wdata_o  = c_bus_wdata_i[32*int'(sel) +: 32];
   assign p_bus_ben_o    = c_bus_ben_i[4*int'(sel) +: 4];

   always_comb begin
      p_bus_re_o = 1'b0;
      p_bus_we_o = 1'b0;
      case (state)
         S_IDLE: begin
            p_bus_re_o = c_bus_re_i[win];
            p_bus_we_o = wr_ok[win];
         end
         S_RETIRE: begin
            p_bus_re_o = rd_pend[grant];
            p_bus_we_o = wr_pend[grant];
         end
         default: ;
      endcase
   end

`ifdef CELLRV32_BUSSWITCH_TIMEOUT_EN
   logic [15:0] tmo_cnt;

   assign tmo = (state == S_BUSY) && (tmo_cnt == 16'(TIMEOUT_CYCLES)) && !p_bus_ack_i && !p_bus_err_i;

   // counter sits at zero outside BUSY, so it is clear on every BUSY entry
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i)               tmo_cnt <= '0;
      else if (state != S_BUSY)  tmo_cnt <= '0;
      else                       tmo_cnt <= tmo_cnt + 16'd1;
   end
`else
   // no watchdog: BUSY waits for the peripheral indefinitely
   assign tmo = (TIMEOUT_CYCLES < 0);
`endif

   assign rsp = (state == S_BUSY) && (p_bus_ack_i || p_bus_err_i || tmo);

   // responses only reach the granted port while a transfer is in flight
   always_comb begin
      c_bus_ack_o   = '0;
      c_bus_err_o   = ro_err;
      c_bus_rdata_o = '0;
      resp_clr      = '0;
      if (state == S_BUSY) begin
         c_bus_ack_o[grant]                  = p_bus_ack_i;
         c_bus_err_o[grant]                  = ro_err[grant] | p_bus_err_i | tmo;
         c_bus_rdata_o[32*int'(grant) +: 32] = p_bus_rdata_i;
         resp_clr[grant]                     = rsp;
      end
   end

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         state      <= S_IDLE;
         grant      <= '0;
         last_grant <= SW'(NUM_PORTS - 1);
         rd_pend    <= '0;
         wr_pend    <= '0;
         ro_err     <= '0;
      end else begin
         rd_pend <= (rd_pend | c_bus_re_i) & ~resp_clr;
         wr_pend <= (wr_pend | wr_ok) & ~resp_clr;
         ro_err  <= c_bus_we_i & READ_ONLY_MASK;
         case (state)
            S_IDLE: begin
               if (win_valid) begin
                  grant <= win;
                  state <= win_strobe ? S_BUSY : S_RETIRE;
               end
            end
            S_RETIRE: state <= S_BUSY;
            default: begin
               if (rsp) begin
                  last_grant <= grant;
                  state      <= S_IDLE;
               end
            end
         endcase
      end
   end

endmodule
